// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, descriptor op codes and loader state enum.
// The control unit decodes against these same opcode/funct values.
package mips_pkg;

   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_MUL = 6'b011100;

   typedef enum logic [3:0] {
      OP_LW   = 4'd0,
      OP_SW   = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_SLT  = 4'd4,
      OP_MUL  = 4'd5,
      OP_ADDI = 4'd6,
      OP_BEQ  = 4'd7,
      OP_J    = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] enc_itype(input logic [5:0] opc, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   // shamt is never used by the supported R-type ops, so it is always zero
   function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: symbolic descriptor -> 32-bit MIPS word plus legal flag.
module mips_instr_pack
   import mips_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (op_e'(op))
         OP_LW:   word = enc_itype(OPC_LW,   rs, rt, imm);
         OP_SW:   word = enc_itype(OPC_SW,   rs, rt, imm);
         OP_ADDI: word = enc_itype(OPC_ADDI, rs, rt, imm);
         OP_BEQ:  word = enc_itype(OPC_BEQ,  rs, rt, imm);
         OP_ADD:  word = enc_rtype(rs, rt, rd, FN_ADD);
         OP_SUB:  word = enc_rtype(rs, rt, rd, FN_SUB);
         OP_SLT:  word = enc_rtype(rs, rt, rd, FN_SLT);
         OP_MUL:  word = enc_rtype(rs, rt, rd, FN_MUL);
         OP_J:    word = {OPC_J, target};
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_imem_loader.sv
// Streams instruction descriptors into consecutive instruction-memory words
// during a start-triggered load session; ends on in_last or a full memory.
module mips_imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              full,
   output logic              err
);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       word;
   logic              legal;
   logic              accept;
   logic              at_limit;
   logic              finish;
   logic              enter_load;

   mips_instr_pack u_pack (
      .op     (in_op),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .imm    (in_imm),
      .target (in_target),
      .word   (word),
      .legal  (legal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)  state_nxt = ST_LOAD;
         ST_LOAD: if (finish) state_nxt = ST_DONE;
         ST_DONE: if (start)  state_nxt = ST_LOAD;
         default:             state_nxt = ST_IDLE;
      endcase
   end

   // The write landing in the last free word ends the session even without in_last
   always_comb begin
      in_ready   = (state == ST_LOAD);
      accept     = in_valid && in_ready;
      at_limit   = legal && (ptr == '1);
      finish     = accept && (in_last || at_limit);
      enter_load = start && (state != ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         count      <= '0;
         done       <= 1'b0;
         full       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (enter_load) begin
            ptr   <= '0;
            count <= '0;
            done  <= 1'b0;
            full  <= 1'b0;
            err   <= 1'b0;
         end else begin
            // count trails the write strobe by one edge
            count <= count + (ADDR_W+1)'(imem_we);
            if (accept) begin
               if (legal) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr;
                  imem_wdata <= word;
                  ptr        <= ptr + ADDR_W'(1);
               end else begin
                  err <= 1'b1;
               end
               if (finish) begin
                  done <= 1'b1;
                  full <= at_limit;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader: a 64-word instance and a 4-word instance,
// expected writes queued at stimulus time and checked by a negedge monitor.
module tb_mips_imem_loader;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_a, start_b;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   logic        a_ready, a_we, a_done, a_full, a_err;
   logic [5:0]  a_addr;
   logic [31:0] a_wdata;
   logic [6:0]  a_count;

   logic        b_ready, b_we, b_done, b_full, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   ptr_a   = 0;
   int   ptr_b   = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   mips_imem_loader #(.ADDR_W(6)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(a_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .imem_we(a_we), .imem_addr(a_addr),
      .imem_wdata(a_wdata), .count(a_count), .done(a_done), .full(a_full), .err(a_err)
   );

   mips_imem_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(b_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .imem_we(b_we), .imem_addr(b_addr),
      .imem_wdata(b_wdata), .count(b_count), .done(b_done), .full(b_full), .err(b_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_start(input bit sel);
      if (!sel) begin start_a = 1'b1; ptr_a = 0; end
      else      begin start_b = 1'b1; ptr_b = 0; end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt, input bit last, input bit legal,
                       input logic [31:0] word);
      exp_t e;
      in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = tgt; in_last = last;
      if (legal) begin
         e.data = word;
         if (!sel) begin e.addr = ptr_a; qa.push_back(e); ptr_a++; end
         else      begin e.addr = ptr_b; qb.push_back(e); ptr_b++; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, " a in_ready"}, 32'(a_ready), 32'd0);
      chk({tag, " a imem_we"},  32'(a_we),    32'd0);
      chk({tag, " a addr"},     32'(a_addr),  32'd0);
      chk({tag, " a wdata"},    a_wdata,      32'd0);
      chk({tag, " a count"},    32'(a_count), 32'd0);
      chk({tag, " a done"},     32'(a_done),  32'd0);
      chk({tag, " a full"},     32'(a_full),  32'd0);
      chk({tag, " a err"},      32'(a_err),   32'd0);
   endtask

   // Write monitor: every strobe must match the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_we) begin
            if (qa.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL a unexpected write: addr %0d data 0x%08h, none required", a_addr, a_wdata);
            end else begin
               e = qa.pop_front();
               n_tests++;
               if (int'(a_addr) != e.addr || a_wdata !== e.data) begin
                  n_fail++;
                  $display("FAIL a write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                           a_addr, a_wdata, e.addr, e.data);
               end
            end
         end
         if (b_we) begin
            if (qb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL b unexpected write: addr %0d data 0x%08h, none required", b_addr, b_wdata);
            end else begin
               e = qb.pop_front();
               n_tests++;
               if (int'(b_addr) != e.addr || b_wdata !== e.data) begin
                  n_fail++;
                  $display("FAIL b write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                           b_addr, b_wdata, e.addr, e.data);
               end
            end
         end
      end
   end

   logic [31:0] full_words [6];

   initial begin
      full_words[0] = 32'h20010001; full_words[1] = 32'h20020002;
      full_words[2] = 32'h20030003; full_words[3] = 32'h20040004;
      full_words[4] = 32'h20050005; full_words[5] = 32'h20060006;

      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_a_zero("reset");
      chk("reset b in_ready", 32'(b_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single ADD with last
      do_start(1'b0);
      chk("t1 in_ready after start", 32'(a_ready), 32'd1);
      send(1'b0, 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
      chk("t1 imem_we", 32'(a_we), 32'd1);
      chk("t1 done with write", 32'(a_done), 32'd1);
      chk("t1 in_ready after last", 32'(a_ready), 32'd0);
      chk("t1 count before update", 32'(a_count), 32'd0);
      @(posedge clk); #1;
      chk("t1 count", 32'(a_count), 32'd1);
      chk("t1 err", 32'(a_err), 32'd0);
      chk("t1 we idle", 32'(a_we), 32'd0);

      // Back-to-back program
      do_start(1'b0);
      chk("t2 done cleared", 32'(a_done), 32'd0);
      chk("t2 count cleared", 32'(a_count), 32'd0);
      send(1'b0, 4'd0, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h8FA80004);
      send(1'b0, 4'd5, 5'd5,  5'd6, 5'd4, 16'h0,    26'h0, 1'b0, 1'b1, 32'h00A6201C);
      send(1'b0, 4'd7, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h1022FFFF);
      send(1'b0, 4'd8, 5'd0,  5'd0, 5'd0, 16'h0,    26'h10, 1'b1, 1'b1, 32'h08000010);
      @(posedge clk); #1;
      chk("t2 count", 32'(a_count), 32'd4);
      chk("t2 done", 32'(a_done), 32'd1);
      chk("t2 full", 32'(a_full), 32'd0);

      // Illegal op between two legal ones
      do_start(1'b0);
      send(1'b0, 4'd2,  5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
      chk("t3 err set", 32'(a_err), 32'd1);
      send(1'b0, 4'd3,  5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00853022);
      @(posedge clk); #1;
      chk("t3 count", 32'(a_count), 32'd2);
      chk("t3 err sticky", 32'(a_err), 32'd1);
      do_start(1'b0);
      chk("t3 err cleared on start", 32'(a_err), 32'd0);
      send(1'b0, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0);
      chk("t3 illegal last done", 32'(a_done), 32'd1);
      chk("t3 illegal last err", 32'(a_err), 32'd1);
      @(posedge clk); #1;
      chk("t3 illegal last count", 32'(a_count), 32'd0);

      // Four-word instance fills up
      do_start(1'b1);
      for (int k = 0; k < 4; k++)
         send(1'b1, 4'd6, 5'd0, 5'(k + 1), 5'd0, 16'(k + 1), 26'h0, 1'b0, 1'b1, full_words[k]);
      chk("t4 full", 32'(b_full), 32'd1);
      chk("t4 done", 32'(b_done), 32'd1);
      chk("t4 in_ready", 32'(b_ready), 32'd0);
      for (int k = 4; k < 6; k++)
         send(1'b1, 4'd6, 5'd0, 5'(k + 1), 5'd0, 16'(k + 1), 26'h0, 1'b0, 1'b0, full_words[k]);
      chk("t4 in_ready held", 32'(b_ready), 32'd0);
      chk("t4 count", 32'(b_count), 32'd4);
      chk("t4 full held", 32'(b_full), 32'd1);

      // Reset mid-stream
      do_start(1'b0);
      send(1'b0, 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      send(1'b0, 4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00853022);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_a_zero("midreset");
      chk("midreset b full", 32'(b_full), 32'd0);
      rst_n = 1'b1;
      do_start(1'b0);
      send(1'b0, 4'd1, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1'b1, 1'b1, 32'hAC430010);
      chk("t5 addr after restart", 32'(a_addr), 32'd0);

      // start during LOAD is ignored
      do_start(1'b0);
      send(1'b0, 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      start_a = 1'b1;
      send(1'b0, 4'd4, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00E8482A);
      start_a = 1'b0;
      chk("t6 addr continues", 32'(a_addr), 32'd1);
      chk("t6 count continues", 32'(a_count), 32'd1);
      send(1'b0, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 1'b1, 32'h0BFFFFFF);
      @(posedge clk); #1;
      chk("t6 count", 32'(a_count), 32'd3);

      repeat (2) @(posedge clk);
      #1;
      chk("a writes outstanding", 32'(qa.size()), 32'd0);
      chk("b writes outstanding", 32'(qb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
